// File: rtl/rab_cfg_regfile.sv
// rab_cfg_regfile: AXI4-Lite slave owning the packed slice-lookup config bus.
// Each 64-bit config reg is two 32-bit AXI words; per-reg writable masks are enforced.
// Build option: define RAB_CFG_READBACK_EN to enable register readback; otherwise
// every read completes with rdata=0 and rresp=SLVERR.
module rab_cfg_regfile #(
    parameter int N_SLICES        = 16,
    parameter int N_REGS          = 4*N_SLICES,
    parameter int ADDR_WIDTH_PHYS = 40,
    parameter int ADDR_WIDTH_VIRT = 32,
    parameter int AXI_ADDR_WIDTH  = 32
) (
    input  logic                      Clk_CI,
    input  logic                      Rst_RI,
    input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [31:0]               wdata,
    input  logic [3:0]                wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic [1:0]                bresp,
    output logic                      bvalid,
    input  logic                      bready,
    input  logic [AXI_ADDR_WIDTH-1:0] araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [31:0]               rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [N_REGS-1:0][63:0]   int_cfg_regs
);

    localparam int IDX_W = $clog2(N_REGS);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    // Address is out of range if any bit above the index field is set or the index exceeds N_REGS-1.
    function automatic logic addr_err(input logic [AXI_ADDR_WIDTH-1:0] a);
        logic [AXI_ADDR_WIDTH-1:0] hi;
        hi = a >> (3 + IDX_W);
        return (hi != '0) ||
               (AXI_ADDR_WIDTH'(a[3 +: IDX_W]) >= AXI_ADDR_WIDTH'(N_REGS));
    endfunction

    // Writable-bit mask of a config reg, selected by its position within the slice.
    function automatic logic [63:0] reg_mask(input logic [1:0] sel);
        int unsigned w;
        logic [63:0] m;
        case (sel)
            2'd0, 2'd1: w = ADDR_WIDTH_VIRT;
            2'd2:       w = ADDR_WIDTH_PHYS;
            default:    w = 4;
        endcase
        for (int unsigned b = 0; b < 64; b++) m[b] = (b < w);
        return m;
    endfunction

    // ---------------- write channel ----------------
    wstate_t                   w_state_q, w_state_d;
    logic                      aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, aw_eff;
    logic [31:0]               w_data_q, w_data_d, w_data_eff;
    logic [3:0]                w_strb_q, w_strb_d, w_strb_eff;
    logic                      awready_d, wready_d, bvalid_d;
    logic [1:0]                bresp_d;
    logic                      aw_take, w_take, wr_en;
    logic [IDX_W-1:0]          wr_idx;
    logic [63:0]               wr_val, wr_bm, wr_data64;
    logic [31:0]               bm32;

    // Write FSM: accept AW and W independently; commit at the edge the second one is taken.
    always_comb begin
        w_state_d  = w_state_q;
        aw_held_d  = aw_held_q;
        aw_addr_d  = aw_addr_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        awready_d  = awready;
        wready_d   = wready;
        bvalid_d   = bvalid;
        bresp_d    = bresp;
        wr_en      = 1'b0;
        aw_take    = awvalid && awready;
        w_take     = wvalid && wready;
        aw_eff     = aw_held_q ? aw_addr_q : awaddr;
        w_data_eff = w_held_q ? w_data_q : wdata;
        w_strb_eff = w_held_q ? w_strb_q : wstrb;
        case (w_state_q)
            W_IDLE: begin
                if (aw_take) begin
                    aw_held_d = 1'b1;
                    aw_addr_d = awaddr;
                    awready_d = 1'b0;
                end else if (!aw_held_q) begin
                    awready_d = 1'b1;
                end
                if (w_take) begin
                    w_held_d = 1'b1;
                    w_data_d = wdata;
                    w_strb_d = wstrb;
                    wready_d = 1'b0;
                end else if (!w_held_q) begin
                    wready_d = 1'b1;
                end
                if ((aw_held_q || aw_take) && (w_held_q || w_take)) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                    if (addr_err(aw_eff)) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        bresp_d = RESP_OKAY;
                        wr_en   = 1'b1;
                    end
                end
            end
            default: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                if (bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
        endcase
    end

    // Merge strobed write data into the addressed word and apply the writable mask.
    always_comb begin
        wr_idx = aw_eff[3 +: IDX_W];
        for (int unsigned b = 0; b < 4; b++) bm32[8*b +: 8] = {8{w_strb_eff[b]}};
        wr_bm     = aw_eff[2] ? {bm32, 32'h0} : {32'h0, bm32};
        wr_data64 = aw_eff[2] ? {w_data_eff, 32'h0} : {32'h0, w_data_eff};
        wr_val    = ((int_cfg_regs[wr_idx] & ~wr_bm) | (wr_data64 & wr_bm)) & reg_mask(wr_idx[1:0]);
    end

    // Write FSM state and handshake registers.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            w_state_q <= W_IDLE;
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            awready   <= 1'b0;
            wready    <= 1'b0;
            bvalid    <= 1'b0;
            bresp     <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            awready   <= awready_d;
            wready    <= wready_d;
            bvalid    <= bvalid_d;
            bresp     <= bresp_d;
        end
    end

    // Config register array: only commit edges change it.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            int_cfg_regs <= '0;
        end else if (wr_en) begin
            int_cfg_regs[wr_idx] <= wr_val;
        end
    end

    // ---------------- read channel ----------------
    rstate_t     r_state_q, r_state_d;
    logic        arready_d, rvalid_d;
    logic [31:0] rdata_d, rd_word;
    logic [1:0]  rresp_d, rd_resp;

`ifdef RAB_CFG_READBACK_EN
    logic [63:0] rd_reg;

    // Read mux: selected word of the addressed reg, as it stands before any same-edge commit.
    always_comb begin
        rd_reg = int_cfg_regs[araddr[3 +: IDX_W]];
        if (addr_err(araddr)) begin
            rd_word = '0;
            rd_resp = RESP_SLVERR;
        end else begin
            rd_word = araddr[2] ? rd_reg[63:32] : rd_reg[31:0];
            rd_resp = RESP_OKAY;
        end
    end
`else
    logic unused_araddr;
    assign unused_araddr = ^araddr;
    assign rd_word       = '0;
    assign rd_resp       = RESP_SLVERR;
`endif

    // Read FSM: latch response on AR handshake, hold it until rready.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready;
        rvalid_d  = rvalid;
        rdata_d   = rdata;
        rresp_d   = rresp;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_word;
                    rresp_d   = rd_resp;
                    r_state_d = R_RESP;
                end else begin
                    arready_d = 1'b1;
                end
            end
            default: begin
                arready_d = 1'b0;
                if (rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
        endcase
    end

    // Read FSM state and response registers.
    always_ff @(posedge Clk_CI or posedge Rst_RI) begin
        if (Rst_RI) begin
            r_state_q <= R_IDLE;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rdata     <= '0;
            rresp     <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready   <= arready_d;
            rvalid    <= rvalid_d;
            rdata     <= rdata_d;
            rresp     <= rresp_d;
        end
    end

endmodule

// File: tb/tb_rab_cfg_regfile.sv
// Directed self-checking bench for rab_cfg_regfile (default parameters).
module tb_rab_cfg_regfile;

    localparam int NR = 64;

`ifdef RAB_CFG_READBACK_EN
    localparam bit          RB    = 1'b1;
    localparam logic [63:0] RB_OK = 64'h0;
`else
    localparam bit          RB    = 1'b0;
    localparam logic [63:0] RB_OK = 64'h2;
`endif

    logic              Clk_CI = 1'b0;
    logic              Rst_RI = 1'b1;
    logic [31:0]       awaddr = '0;
    logic              awvalid = 1'b0;
    logic              awready;
    logic [31:0]       wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              wvalid = 1'b0;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready = 1'b0;
    logic [31:0]       araddr = '0;
    logic              arvalid = 1'b0;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready = 1'b0;
    logic [NR-1:0][63:0] int_cfg_regs;

    logic [NR-1:0][63:0] exp_regs;
    int n_checks = 0;
    int n_pass   = 0;

    rab_cfg_regfile #(
        .N_SLICES        (16),
        .ADDR_WIDTH_PHYS (40),
        .ADDR_WIDTH_VIRT (32),
        .AXI_ADDR_WIDTH  (32)
    ) dut (
        .Clk_CI       (Clk_CI),
        .Rst_RI       (Rst_RI),
        .awaddr       (awaddr),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready),
        .araddr       (araddr),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .rready       (rready),
        .int_cfg_regs (int_cfg_regs)
    );

    always #5 Clk_CI = ~Clk_CI;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge Clk_CI);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
        logic aw_hs, w_hs, b_hs, done;
        logic [1:0] r;
        resp    = 2'bxx;
        done    = 1'b0;
        awaddr  = a;
        awvalid = 1'b1;
        wdata   = d;
        wstrb   = s;
        wvalid  = 1'b1;
        bready  = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            r     = bresp;
            tick();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
            if (b_hs) begin
                resp = r;
                done = 1'b1;
            end
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] data, output logic [1:0] resp);
        logic ar_hs, r_hs, done;
        logic [31:0] dq;
        logic [1:0]  rq;
        data    = 'x;
        resp    = 2'bxx;
        done    = 1'b0;
        araddr  = a;
        arvalid = 1'b1;
        rready  = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            dq    = rdata;
            rq    = rresp;
            tick();
            if (ar_hs) arvalid = 1'b0;
            if (r_hs) begin
                data = dq;
                resp = rq;
                done = 1'b1;
            end
        end
        arvalid = 1'b0;
        rready  = 1'b0;
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        exp_regs = '0;

        // reset values while reset is held
        repeat (3) tick();
        chk("rst_awready", 64'(awready), 64'h0);
        chk("rst_wready", 64'(wready), 64'h0);
        chk("rst_arready", 64'(arready), 64'h0);
        chk("rst_bvalid", 64'(bvalid), 64'h0);
        chk("rst_rvalid", 64'(rvalid), 64'h0);
        chk("rst_bresp", 64'(bresp), 64'h0);
        chk("rst_rresp", 64'(rresp), 64'h0);
        chk("rst_rdata", 64'(rdata), 64'h0);
        chk("rst_regs", 64'(int_cfg_regs === exp_regs), 64'h1);
        Rst_RI = 1'b0;
        tick();
        tick();
        chk("idle_awready", 64'(awready), 64'h1);
        chk("idle_arready", 64'(arready), 64'h1);

        // reg0 lo
        do_write(32'h000, 32'hDEAD_BEEF, 4'hF, resp);
        exp_regs[0] = 64'h0000_0000_DEAD_BEEF;
        chk("wr0_bresp", 64'(resp), 64'h0);
        chk("wr0_reg0", int_cfg_regs[0], 64'h0000_0000_DEAD_BEEF);

        // reg2 hi: only 40 phys bits writable
        do_write(32'h014, 32'hFFFF_FFFF, 4'hF, resp);
        exp_regs[2] = 64'h0000_00FF_0000_0000;
        chk("wr2_bresp", 64'(resp), 64'h0);
        chk("wr2_reg2", int_cfg_regs[2], 64'h0000_00FF_0000_0000);

        // reg3 lo: flags only
        do_write(32'h018, 32'hFFFF_FFFF, 4'hF, resp);
        exp_regs[3] = 64'h0000_0000_0000_000F;
        chk("wr3_reg3", int_cfg_regs[3], 64'h0000_0000_0000_000F);

        // reg0 hi: virt reg has no writable high bits
        do_write(32'h004, 32'hFFFF_FFFF, 4'hF, resp);
        chk("wr0hi_bresp", 64'(resp), 64'h0);
        chk("wr0hi_regs", 64'(int_cfg_regs === exp_regs), 64'h1);

        do_read(32'h018, rd, resp);
        chk("rd3_rdata", 64'(rd), RB ? 64'hF : 64'h0);
        chk("rd3_rresp", 64'(resp), RB_OK);
        do_read(32'h014, rd, resp);
        chk("rd2hi_rdata", 64'(rd), RB ? 64'hFF : 64'h0);
        chk("rd2hi_rresp", 64'(resp), RB_OK);
        do_read(32'h200, rd, resp);
        chk("rd_oor_rdata", 64'(rd), 64'h0);
        chk("rd_oor_rresp", 64'(resp), 64'h2);

        // W three cycles ahead of AW, single byte strobe
        wvalid = 1'b1;
        wdata  = 32'h0000_AB00;
        wstrb  = 4'b0010;
        tick();
        wvalid = 1'b0;
        chk("wfirst_wready", 64'(wready), 64'h0);
        chk("wfirst_bvalid", 64'(bvalid), 64'h0);
        tick();
        tick();
        chk("wfirst_bvalid_wait", 64'(bvalid), 64'h0);
        chk("wfirst_reg1_wait", int_cfg_regs[1], 64'h0);
        awaddr  = 32'h008;
        awvalid = 1'b1;
        chk("wfirst_awready", 64'(awready), 64'h1);
        tick();
        awvalid = 1'b0;
        exp_regs[1] = 64'h0000_0000_0000_AB00;
        chk("wfirst_bvalid_aw1", 64'(bvalid), 64'h1);
        chk("wfirst_bresp", 64'(bresp), 64'h0);
        chk("wfirst_regs", 64'(int_cfg_regs === exp_regs), 64'h1);
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("wfirst_bvalid_done", 64'(bvalid), 64'h0);

        // out-of-range write
        do_write(32'h200, 32'hFFFF_FFFF, 4'hF, resp);
        chk("wr_oor_bresp", 64'(resp), 64'h2);
        chk("wr_oor_regs", 64'(int_cfg_regs === exp_regs), 64'h1);

        // read and write commit to the same word on one edge, both responses stalled
        do_write(32'h020, 32'h0000_1111, 4'hF, resp);
        exp_regs[4] = 64'h0000_0000_0000_1111;
        chk("wr4_reg4", int_cfg_regs[4], 64'h0000_0000_0000_1111);
        awaddr  = 32'h020;
        awvalid = 1'b1;
        wdata   = 32'h1234_5678;
        wstrb   = 4'hF;
        wvalid  = 1'b1;
        araddr  = 32'h020;
        arvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        exp_regs[4] = 64'h0000_0000_1234_5678;
        chk("same_reg4", int_cfg_regs[4], 64'h0000_0000_1234_5678);
        for (int i = 0; i < 5; i++) begin
            chk("stall_bvalid", 64'(bvalid), 64'h1);
            chk("stall_bresp", 64'(bresp), 64'h0);
            chk("stall_rvalid", 64'(rvalid), 64'h1);
            chk("stall_rdata", 64'(rdata), RB ? 64'h1111 : 64'h0);
            chk("stall_rresp", 64'(rresp), RB_OK);
            chk("stall_awready", 64'(awready), 64'h0);
            chk("stall_arready", 64'(arready), 64'h0);
            tick();
        end
        bready = 1'b1;
        rready = 1'b1;
        tick();
        bready = 1'b0;
        rready = 1'b0;
        chk("stall_bvalid_done", 64'(bvalid), 64'h0);
        chk("stall_rvalid_done", 64'(rvalid), 64'h0);

        // reset while holding a write response
        awaddr  = 32'h028;
        awvalid = 1'b1;
        wdata   = 32'h0000_0BAD;
        wstrb   = 4'hF;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        chk("pre_rst_bvalid", 64'(bvalid), 64'h1);
        chk("pre_rst_reg5", int_cfg_regs[5], 64'h0000_0000_0000_0BAD);
        #2;
        Rst_RI = 1'b1;
        #1;
        exp_regs = '0;
        chk("async_rst_bvalid", 64'(bvalid), 64'h0);
        chk("async_rst_awready", 64'(awready), 64'h0);
        chk("async_rst_regs", 64'(int_cfg_regs === exp_regs), 64'h1);
        tick();
        tick();
        Rst_RI = 1'b0;
        tick();
        tick();

        // recovery after reset, low-byte strobe on reg6
        do_write(32'h030, 32'hFFFF_FF55, 4'b0001, resp);
        exp_regs[6] = 64'h0000_0000_0000_0055;
        chk("post_rst_bresp", 64'(resp), 64'h0);
        chk("post_rst_regs", 64'(int_cfg_regs === exp_regs), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
